// File: rtl/cart_mbc1.sv
// MBC1 cartridge responder: decodes Game Boy bus strobes into MBC1 bank
// register updates and req/ack transactions on a flat ROM/RAM memory port.
module cart_mbc1 #(
    parameter int         ROM_ADDR_W    = 21,
    parameter int         RAM_ADDR_W    = 15,
    parameter logic [6:0] ROM_BANK_MASK = 7'h7F
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           a,
    input  logic [7:0]            d_wr,
    output logic [7:0]            d_rd,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  cs,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_ram,
    output logic [ROM_ADDR_W-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One memory transaction, fully resolved at the moment the bus event occurs.
    typedef struct packed {
        logic                  we;
        logic                  ram;
        logic [ROM_ADDR_W-1:0] addr;
        logic [7:0]            wdata;
    } txn_t;

    // Bus history used for edge / address-change event detection.
    logic        wr_q, rd_q;
    logic [15:0] a_q;

    // MBC1 control registers.
    logic       ram_en_q, ram_en_d;
    logic [4:0] bank1_q, bank1_d;
    logic [1:0] bank2_q, bank2_d;
    logic       mode_q, mode_d;

    // Transaction engine state.
    state_t     state_q, state_d;
    txn_t       cur_q, cur_d;
    txn_t       pend_q, pend_d;
    logic       pend_v_q, pend_v_d;
    logic       mem_req_q, mem_req_d;
    logic       busy_q, busy_d;
    logic [7:0] d_rd_q, d_rd_d;

    // Decode intermediates.
    logic                  write_ev, read_ev;
    logic                  is_rom, is_ram, ram_ok;
    logic                  ev_mem;
    logic [6:0]            rom_bank;
    logic [20:0]           rom_full;
    logic [14:0]           ram_full;
    txn_t                  ev_txn;

    // Decode bus events and map the current address to a memory transaction.
    always_comb begin
        write_ev = wr & ~wr_q;
        // A write strobe masks any read in the same cycle.
        read_ev  = rd & ~wr & (~rd_q | (a != a_q));

        is_rom = ~a[15];
        is_ram = (a[15:13] == 3'b101);
        ram_ok = cs & ram_en_q;

        if (a[14]) begin
            rom_bank = {bank2_q, bank1_q} & ROM_BANK_MASK;
        end else begin
            rom_bank = (mode_q ? {bank2_q, 5'd0} : 7'd0) & ROM_BANK_MASK;
        end
        rom_full = {rom_bank, a[13:0]};
        ram_full = {(mode_q ? bank2_q : 2'd0), a[12:0]};

        ev_txn.we    = write_ev;
        ev_txn.ram   = is_ram;
        ev_txn.addr  = is_ram ? ROM_ADDR_W'(ram_full[RAM_ADDR_W-1:0])
                              : rom_full[ROM_ADDR_W-1:0];
        ev_txn.wdata = d_wr;

        ev_mem = (read_ev & is_rom) | ((read_ev | write_ev) & is_ram & ram_ok);
    end

    // Register writes, disabled-RAM reads and the IDLE/REQ/DONE transaction FSM.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
        ram_en_d  = ram_en_q;
        bank1_d   = bank1_q;
        bank2_d   = bank2_q;
        mode_d    = mode_q;
        state_d   = state_q;
        cur_d     = cur_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        mem_req_d = mem_req_q;
        busy_d    = busy_q;
        d_rd_d    = d_rd_q;

        // Bank registers update immediately, even with a transaction in flight.
        if (write_ev && is_rom) begin
            case (a[14:13])
                2'd0: ram_en_d = (d_wr[3:0] == 4'hA);
                2'd1: bank1_d  = (d_wr[4:0] == 5'd0) ? 5'd1 : d_wr[4:0];
                2'd2: bank2_d  = d_wr[1:0];
                default: mode_d = d_wr[0];
            endcase
        end

        // Reads of unmapped/disabled cartridge RAM float high.
        if (read_ev && is_ram && !ram_ok) begin
            d_rd_d = 8'hFF;
        end

        case (state_q)
            ST_IDLE: begin
                if (ev_mem) begin
                    cur_d     = ev_txn;
                    mem_req_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ev_mem) begin
                    pend_d   = ev_txn;
                    pend_v_d = 1'b1;
                end
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!cur_q.we) begin
                        d_rd_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A fresh event this cycle supersedes the stored one (last wins).
                if (ev_mem) begin
                    cur_d     = ev_txn;
                    pend_v_d  = 1'b0;
                    mem_req_d = 1'b1;
                    state_d   = ST_REQ;
                end else if (pend_v_q) begin
                    cur_d     = pend_q;
                    pend_v_d  = 1'b0;
                    mem_req_d = 1'b1;
                    state_d   = ST_REQ;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops the request and clears banks asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            a_q       <= 16'h0000;
            ram_en_q  <= 1'b0;
            bank1_q   <= 5'd1;
            bank2_q   <= 2'd0;
            mode_q    <= 1'b0;
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            d_rd_q    <= 8'hFF;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            wr_q      <= wr;
            rd_q      <= rd;
            a_q       <= a;
            ram_en_q  <= ram_en_d;
            bank1_q   <= bank1_d;
            bank2_q   <= bank2_d;
            mode_q    <= mode_d;
            state_q   <= state_d;
            cur_q     <= cur_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            mem_req_q <= mem_req_d;
            busy_q    <= busy_d;
            d_rd_q    <= d_rd_d;
        end
    end

    assign d_rd      = d_rd_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = cur_q.we;
    assign mem_ram   = cur_q.ram;
    assign mem_addr  = cur_q.addr;
    assign mem_wdata = cur_q.wdata;
    assign busy      = busy_q;

endmodule

// File: doc/cart_mbc1.md
Name: cart_mbc1

Overview:
Cartridge-side responder for the Game Boy cartridge bus (a, d, wr, rd, cs) driven by the gameboy top level. Implements MBC1 bank control (RAM enable, ROM bank, RAM/upper bank, mode) and translates each bus access into a req/ack transaction on a flat external memory port (ROM flash + battery RAM). Returns read data on d_rd for the cartridge tristate path.

Parameters:
ROM_ADDR_W, 21, external ROM byte-address width (2 MB max)
RAM_ADDR_W, 15, external RAM byte-address width (32 KB max)
ROM_BANK_MASK, 7'h7F, AND-mask on the 7-bit effective ROM bank (cart size)

Ports:
clk  input  1  system clock (4.19 MHz domain)
rst  input  1  asynchronous reset, active-high
a  input  16  cartridge address bus
d_wr  input  8  write data from gameboy
d_rd  output  8  read data to gameboy
wr  input  1  write enable, level
rd  input  1  read enable, level
cs  input  1  external RAM chip select, active-high
mem_req  output  1  external memory request
mem_we  output  1  1 = write, 0 = read; valid while mem_req
mem_ram  output  1  1 = RAM space, 0 = ROM space; valid while mem_req
mem_addr  output  21  byte address (RAM uses low RAM_ADDR_W bits)
mem_wdata  output  8  write data
mem_rdata  input  8  read data, valid with mem_ack
mem_ack  input  1  single-cycle completion strobe
busy  output  1  transaction outstanding

Behaviour:
- Reset (async): ram_en=0, bank1=5'd1, bank2=2'd0, mode=0, d_rd=8'hFF, mem_req=0, mem_we=0, mem_ram=0, mem_addr=0, mem_wdata=0, busy=0, FSM=IDLE, pending cleared.
- Event detection: wr_q, rd_q, a_q registered each clk. Write event = wr & ~wr_q. Read event = rd & ~wr & (~rd_q | a != a_q). wr and rd both high: write wins, no read event.
- Register writes (write event, a < 16'h8000), complete in the event cycle, no memory access:
  - 0000-1FFF: ram_en = (d_wr[3:0] == 4'hA).
  - 2000-3FFF: bank1 = d_wr[4:0]; 5'd0 stored as 5'd1.
  - 4000-5FFF: bank2 = d_wr[1:0].
  - 6000-7FFF: mode = d_wr[0].
- Address map (7-bit ROM bank, then & ROM_BANK_MASK):
  - ROM 0000-3FFF: bank = mode ? {bank2,5'd0} : 7'd0.
  - ROM 4000-7FFF: bank = {bank2,bank1}.
  - ROM mem_addr = {bank, a[13:0]}.
  - RAM A000-BFFF with cs: mem_addr = {mode ? bank2 : 2'd0, a[12:0]}, zero-extended.
- Memory-bound events: read of ROM; read/write of RAM when cs & ram_en. RAM read with ram_en=0 or cs=0: d_rd=8'hFF next cycle, no request. RAM write with ram_en=0: dropped. Other addresses: ignored, d_rd unchanged.
- FSM IDLE -> REQ -> DONE -> IDLE:
  - IDLE: memory-bound event in cycle N -> cycle N+1: mem_req=1, mem_we/mem_ram/mem_addr/mem_wdata latched, busy=1, state REQ.
  - REQ: outputs held stable until mem_ack. On ack: read -> d_rd=mem_rdata next cycle; mem_req=0 next cycle; state DONE.
  - DONE: one cycle; if pending set, issue it (back to REQ), else IDLE with busy=0.
  - Minimum latency: event to d_rd valid = 3 cycles with same-cycle ack.
- Pending: one slot. Memory-bound event while not IDLE is stored; a later event overwrites it (last wins). Register writes apply immediately, even while busy; an in-flight transaction keeps its latched address.
- mem_ack outside REQ is ignored.
- Reset mid-transaction: mem_req drops immediately (async), pending discarded, bank state cleared.

Test Plan:
- Reset then read a=16'h0150: mem_req with mem_addr=21'h000150, mem_ram=0; ack with mem_rdata=8'h3C -> d_rd=8'h3C, busy=0.
- Write 8'h00 to 16'h2000, read 16'h4000 -> mem_addr=21'h004000 (bank 1). Write 8'h05 to 2000, 8'h02 to 4000, read 16'h7FFF -> mem_addr=21'h117FFF.
- mode=1, bank2=1: read 16'h0000 -> mem_addr=21'h080000. With ROM_BANK_MASK=7'h1F the same read -> 21'h000000.
- RAM: read A000 with ram_en=0 -> d_rd=8'hFF, no mem_req. Write 8'h0A to 0000, mode=1, bank2=3, write 8'h5A to A123 with cs=1 -> mem_we=1, mem_ram=1, mem_addr=21'h006123, mem_wdata=8'h5A.
- Hold ack off: read 0150, then read 0151 and 0152 while busy -> after first ack, exactly one further request, addr 21'h000152.
- Assert rst while mem_req=1 -> mem_req=0 same cycle, d_rd=8'hFF, bank1=1; a later read of 16'h4000 maps to bank 1.
